// File: rtl/alu_bool_arbiter.sv
// ---------------------------------------------------------------------------
// alu_bool_arbiter
//
// Round-robin arbiter/sequencer that shares one external combinational
// 32-bit boolean ALU (XOR / NE) among N_REQ requesters. One requester is
// granted per cycle, its operands are muxed onto the ALU, and the ALU result
// is captured into a one-entry output slot tagged with the requester index.
//
// Optional feature macro: ALU_BOOL_ARB_ERR_EN
//   When defined, the resp_err port exists and flags results produced by
//   an illegal opcode (anything other than 3'b011 XOR or 3'b100 NE).
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    per-requester request valid                  [N_REQ]
//   req_ready    per-requester accept, one-hot or zero        [N_REQ]
//   req_a/req_b  packed operands, requester i at [32i+31:32i] [N_REQ*32]
//   req_opcode   packed opcodes, requester i at [3i+2:3i]     [N_REQ*3]
//   alu_a/alu_b  operands to the shared ALU                   [32]
//   alu_opcode   opcode to the shared ALU, 0 when no grant    [3]
//   alu_result   combinational result from the shared ALU     [32]
//   resp_valid   output slot holds a result
//   resp_ready   consumer accepts the result
//   resp_id      requester index that produced resp_result    [ID_W]
//   resp_result  captured ALU result                          [32]
//   resp_err     illegal-opcode flag (ALU_BOOL_ARB_ERR_EN only)
// ---------------------------------------------------------------------------
module alu_bool_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    input  logic [N_REQ*3-1:0]   req_opcode,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_opcode,
    input  logic [31:0]          alu_result,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [31:0]          resp_result
`ifdef ALU_BOOL_ARB_ERR_EN
    ,
    output logic                 resp_err
`endif
);

    logic [31:0]     a_arr  [N_REQ];
    logic [31:0]     b_arr  [N_REQ];
    logic [2:0]      op_arr [N_REQ];

    logic            resp_valid_reg;
    logic [ID_W-1:0] resp_id_reg;
    logic [31:0]     resp_result_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] rr_ptr_next;

    logic            slot_free;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;

    // Unpack the flat request buses into per-requester arrays.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[32*gi +: 32];
            assign b_arr[gi]  = req_b[32*gi +: 32];
            assign op_arr[gi] = req_opcode[3*gi +: 3];
        end
    endgenerate

    // A full slot can be refilled in the same cycle it is drained.
    assign slot_free = !resp_valid_reg || resp_ready;

    // Rotating priority search starting at rr_ptr. The candidate index is
    // kept one bit wider so the wrap works for non-power-of-two N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (!rst && slot_free) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
                if (cand >= (ID_W+1)'(N_REQ)) begin
                    cand = cand - (ID_W+1)'(N_REQ);
                end
                if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand[ID_W-1:0];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_found && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign alu_a      = grant_found ? a_arr[grant_idx]  : 32'd0;
    assign alu_b      = grant_found ? b_arr[grant_idx]  : 32'd0;
    assign alu_opcode = grant_found ? op_arr[grant_idx] : 3'b000;

    assign rr_ptr_next = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg  <= 1'b0;
            resp_id_reg     <= '0;
            resp_result_reg <= 32'd0;
            rr_ptr_reg      <= '0;
        end else if (grant_found) begin
            resp_valid_reg  <= 1'b1;
            resp_id_reg     <= grant_idx;
            resp_result_reg <= alu_result;
            rr_ptr_reg      <= rr_ptr_next;
        end else if (resp_ready) begin
            // Drain only; id and result keep their last values.
            resp_valid_reg  <= 1'b0;
        end
    end

    assign resp_valid  = resp_valid_reg;
    assign resp_id     = resp_id_reg;
    assign resp_result = resp_result_reg;

`ifdef ALU_BOOL_ARB_ERR_EN
    logic resp_err_reg;
    logic op_illegal;

    assign op_illegal = !((alu_opcode == 3'b011) || (alu_opcode == 3'b100));

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err_reg <= 1'b0;
        end else if (grant_found) begin
            resp_err_reg <= op_illegal;
        end
    end

    assign resp_err = resp_err_reg;
`endif

endmodule
